// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: drives a registered instruction memory and aligns data with its PC.
// Define FETCH_HALT_DETECT_EN to stop fetching once HALT_OPCODE is delivered.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    INS_WIDTH   = 9,
    parameter logic [ADDR_WIDTH-1:0] START_PC    = '0,
    parameter logic [INS_WIDTH-1:0]  HALT_OPCODE = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic [ADDR_WIDTH-1:0] PC_address,
    output logic                  rEn,
    input  logic [INS_WIDTH-1:0]  mem_ins,
    output logic [INS_WIDTH-1:0]  ins_out,
    output logic [ADDR_WIDTH-1:0] ins_pc,
    output logic                  ins_valid,
    output logic                  halted
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] ins_pc_q, ins_pc_d;
    logic                  valid_q, valid_d;
    logic                  halt_hit;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit = valid_q && (mem_ins == HALT_OPCODE);
`else
    logic unused_halt_opcode;
    assign unused_halt_opcode = ^HALT_OPCODE;
    assign halt_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ins_pc_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ins_pc_q <= ins_pc_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ins_pc_d = ins_pc_q;
        valid_d  = valid_q;
        rEn      = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                end
            end
            RUN: begin
                // Stall freezes everything; memory holds its output while rEn=0.
                if (!stall) begin
                    rEn      = 1'b1;
                    ins_pc_d = pc_q;
                    valid_d  = 1'b1;
                    if (halt_hit) begin
                        // Read issued this cycle is dropped; halt word itself was just delivered.
                        state_d = HALT;
                        valid_d = 1'b0;
                    end else if (jump_en) begin
                        pc_d    = jump_addr;
                        valid_d = 1'b0;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign PC_address = pc_q;
    assign ins_out    = mem_ins;
    assign ins_pc     = ins_pc_q;
    assign ins_valid  = valid_q;
    assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered instruction memory holding mem[n]=n.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       jump_en = 1'b0;
    logic [7:0] jump_addr = 8'h00;
    logic [7:0] PC_address;
    logic       rEn;
    logic [8:0] mem_ins = 9'h000;
    logic [8:0] ins_out;
    logic [7:0] ins_pc;
    logic       ins_valid;
    logic       halted;

    logic [8:0] mem [256];
    int         n_checks = 0;
    int         n_errors = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .PC_address (PC_address),
        .rEn        (rEn),
        .mem_ins    (mem_ins),
        .ins_out    (ins_out),
        .ins_pc     (ins_pc),
        .ins_valid  (ins_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rEn) mem_ins <= mem[PC_address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One delivered instruction: valid, pc and data (mem[n]=n).
    task automatic chk_ins(input string tag, input logic [7:0] pc);
        chk({tag, ".valid"}, 32'(ins_valid), 32'd1);
        chk({tag, ".pc"},    32'(ins_pc),    32'(pc));
        chk({tag, ".ins"},   32'(ins_out),   32'(pc));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 9'(i);

        // reset state
        tick(); tick();
        chk("rst.pc",     32'(PC_address), 32'h0);
        chk("rst.ren",    32'(rEn),        32'h0);
        chk("rst.inspc",  32'(ins_pc),     32'h0);
        chk("rst.valid",  32'(ins_valid),  32'h0);
        chk("rst.halted", 32'(halted),     32'h0);
        rst = 1'b0;
        tick();
        chk("idle.ren", 32'(rEn), 32'h0);

        // sequential fetch
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("seq.ren1",   32'(rEn),        32'h1);
        chk("seq.pc1",    32'(PC_address), 32'h0);
        chk("seq.valid1", 32'(ins_valid),  32'h0);
        for (int p = 0; p <= 5; p++) begin
            tick();
            chk_ins($sformatf("seq%0d", p), 8'(p));
        end

        // stall 3 cycles at ins_pc=5
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d.ren", i), 32'(rEn),        32'h0);
            chk($sformatf("stall%0d.pc", i),  32'(PC_address), 32'h6);
            chk_ins($sformatf("stall%0d", i), 8'd5);
            if (i < 2) tick();
        end
        tick();
        stall = 1'b0;
        #1;
        chk("rel.ren", 32'(rEn), 32'h1);
        chk_ins("rel", 8'd5);
        for (int p = 6; p <= 9; p++) begin
            tick();
            chk_ins($sformatf("post%0d", p), 8'(p));
        end

        // jump while fetching PC 10
        chk("jmp.pcpre", 32'(PC_address), 32'd10);
        jump_en = 1'b1; jump_addr = 8'h40;
        tick();
        jump_en = 1'b0;
        chk("jmp.flush", 32'(ins_valid),  32'h0);
        chk("jmp.pc",    32'(PC_address), 32'h40);
        tick(); chk_ins("jmp40", 8'h40);
        tick(); chk_ins("jmp41", 8'h41);

        // stall beats jump; jump taken once stall drops
        stall = 1'b1; jump_en = 1'b1; jump_addr = 8'h80;
        tick();
        chk("sj.pc",    32'(PC_address), 32'h42);
        chk("sj.inspc", 32'(ins_pc),     32'h41);
        stall = 1'b0;
        tick();
        jump_en = 1'b0;
        chk("sj.flush", 32'(ins_valid),  32'h0);
        chk("sj.pc2",   32'(PC_address), 32'h80);
        tick(); chk_ins("sj80", 8'h80);

        // wrap-around
        jump_en = 1'b1; jump_addr = 8'hFE;
        tick();
        jump_en = 1'b0;
        tick(); chk_ins("wrapFE", 8'hFE);
        tick(); chk_ins("wrapFF", 8'hFF);
        chk("wrap.pc", 32'(PC_address), 32'h0);
        tick(); chk_ins("wrap00", 8'h00);

        // start ignored in RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_ins("runstart", 8'h01);
        chk("runstart.pc", 32'(PC_address), 32'h2);

        // reset mid-stall with jump pending
        stall = 1'b1; jump_en = 1'b1; jump_addr = 8'h33; rst = 1'b1;
        tick();
        chk("mrst.pc",     32'(PC_address), 32'h0);
        chk("mrst.ren",    32'(rEn),        32'h0);
        chk("mrst.inspc",  32'(ins_pc),     32'h0);
        chk("mrst.valid",  32'(ins_valid),  32'h0);
        chk("mrst.halted", 32'(halted),     32'h0);
        rst = 1'b0; stall = 1'b0;
        tick();
        // jump ignored in IDLE
        jump_en = 1'b0;
        chk("idlejmp.pc",  32'(PC_address), 32'h0);
        chk("idlejmp.ren", 32'(rEn),        32'h0);

        // halt opcode at address 3
        mem[3] = 9'h1FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p <= 3; p++) tick();
        chk("h.valid", 32'(ins_valid), 32'h1);
        chk("h.pc",    32'(ins_pc),    32'h3);
        chk("h.ins",   32'(ins_out),   32'h1FF);
        tick();
`ifdef FETCH_HALT_DETECT_EN
        chk("h.halted", 32'(halted),    32'h1);
        chk("h.ren",    32'(rEn),       32'h0);
        chk("h.valid2", 32'(ins_valid), 32'h0);
        jump_en = 1'b1; jump_addr = 8'h20;
        tick();
        jump_en = 1'b0;
        chk("h.hold",   32'(halted),    32'h1);
        chk("h.valid3", 32'(ins_valid), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("h.clr", 32'(halted),     32'h0);
        chk("h.ren2", 32'(rEn),       32'h1);
        chk("h.pc0", 32'(PC_address), 32'h0);
        tick(); chk_ins("h.restart", 8'h00);
`else
        chk("nh.halted", 32'(halted), 32'h0);
        chk("nh.ren",    32'(rEn),    32'h1);
        chk_ins("nh4", 8'h04);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
